lwc36_encr_core: RTL and testbench

- Iterative lightweight block-cipher encryption core: 36-bit plaintext, 144-bit key, one round per clock.
- Integrates three sub-functions as one block:
  - round-key generator (key_gen role)
  - two 9-bit substitution functions (sbox / S_box_2 roles)
  - round datapath and control (encr role)
- Sits between the host, which supplies the key and block and pulses start, and the consumer of the ciphertext, which waits for done.

---
 rtl/lwc36_encr_core.sv | 120 ++++++++++++
 tb/tb_lwc36_encr_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lwc36_encr_core.sv
// Iterative 36-bit block encryption core, 144-bit key, one round per clock.
// Round keys, both S-boxes and the round datapath are evaluated in one cycle.
module lwc36_encr_core #(
    parameter int unsigned ROUNDS = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         encrypt_en,
    input  logic [35:0]  S_I,
    input  logic [143:0] keyin,
    output logic [35:0]  S_j,
    output logic         encr_done,
    output logic [6:0]   round_no
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         r_fsm;
    logic [35:0]    r_state;
    logic [143:0]   r_key;
    logic [35:0]    r_sj;
    logic           r_done;
    logic [6:0]     r_round;

    logic [8:0]     w_kw [16];
    logic [3:0]     w_i1;
    logic [3:0]     w_i2;
    logic [3:0]     w_i3;
    logic [8:0]     w_k1;
    logic [8:0]     w_k2;
    logic [8:0]     w_k3;
    logic [8:0]     w_a;
    logic [8:0]     w_b;
    logic [8:0]     w_c;
    logic [35:0]    w_next;
    logic           w_last;

    function automatic logic [8:0] sb1(input logic [8:0] x);
        logic [8:0] y;
        y = '0;
        for (int i = 0; i < 9; i++) begin
            y[i] = x[i] ^ (~x[(i + 1) % 9] & x[(i + 2) % 9]);
        end
        return y;
    endfunction

    function automatic logic [8:0] sb2(input logic [8:0] x);
        logic [8:0] t;
        t = sb1(x);
        return {t[5:0], t[8:6]} ^ 9'h0A5;
    endfunction

    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_kw[j] = r_key[143 - 9 * j -: 9];
        end
    end

    // (3r) mod 16 only depends on r mod 16
    assign w_i1 = r_round[3:0] * 4'd3;
    assign w_i2 = w_i1 + 4'd1;
    assign w_i3 = w_i1 + 4'd2;

    assign w_k1 = w_kw[w_i1];
    assign w_k2 = w_kw[w_i2];
    assign w_k3 = w_kw[w_i3] ^ {2'b00, r_round};

    assign w_a = sb1(r_state[35:27] ^ w_k1);
    assign w_b = sb2(r_state[26:18] ^ w_k2);
    assign w_c = sb1(r_state[17:9]  ^ w_k3);

    assign w_next = {r_state[26:18] ^ w_a,
                     r_state[17:9]  ^ w_b,
                     r_state[8:0]   ^ w_c,
                     r_state[35:27]};

    assign w_last = (r_round == 7'(ROUNDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_sj    <= '0;
            r_done  <= 1'b0;
            r_round <= '0;
        end else begin
            unique case (r_fsm)
                IDLE, DONE: begin
                    if (encrypt_en) begin
                        r_state <= S_I;
                        r_key   <= keyin;
                        r_round <= '0;
                        r_done  <= 1'b0;
                        r_fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    r_state <= w_next;
                    r_round <= r_round + 7'd1;
                    if (w_last) begin
                        r_sj   <= w_next;
                        r_done <= 1'b1;
                        r_fsm  <= DONE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign S_j       = r_sj;
    assign encr_done = r_done;
    assign round_no  = r_round;

endmodule

// File: tb/tb_lwc36_encr_core.sv
// Bench for lwc36_encr_core: directed vectors, random runs against a model,
// restart/reset behaviour and exhaustive S-box recovery through a 1-round core.
module tb_lwc36_encr_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         en1, en24;
    logic [35:0]  si1, si24;
    logic [143:0] k1, k24;
    logic [35:0]  sj1, sj24;
    logic         done1, done24;
    logic [6:0]   rn1, rn24;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lwc36_encr_core #(.ROUNDS(1)) u_r1 (
        .clk        (clk),
        .rst        (rst),
        .encrypt_en (en1),
        .S_I        (si1),
        .keyin      (k1),
        .S_j        (sj1),
        .encr_done  (done1),
        .round_no   (rn1)
    );

    lwc36_encr_core u_r24 (
        .clk        (clk),
        .rst        (rst),
        .encrypt_en (en24),
        .S_I        (si24),
        .keyin      (k24),
        .S_j        (sj24),
        .encr_done  (done24),
        .round_no   (rn24)
    );

    // Reference S-boxes via whole-word rotations
    function automatic logic [8:0] m_sb1(input logic [8:0] x);
        logic [17:0] d;
        logic [8:0]  r1;
        logic [8:0]  r2;
        d  = {x, x};
        r1 = d[9:1];
        r2 = d[10:2];
        return x ^ (~r1 & r2);
    endfunction

    function automatic logic [8:0] m_sb2(input logic [8:0] x);
        logic [8:0] t;
        logic [8:0] rl;
        t  = m_sb1(x);
        rl = (t << 3) | (t >> 6);
        return rl ^ 9'h0A5;
    endfunction

    function automatic logic [35:0] model(input logic [35:0] pt,
                                          input logic [143:0] key,
                                          input int rounds);
        logic [8:0] w [4];
        logic [8:0] k [16];
        logic [8:0] a, b, c, t0;
        for (int j = 0; j < 16; j++) k[j] = key[143 - 9 * j -: 9];
        w[0] = pt[35:27];
        w[1] = pt[26:18];
        w[2] = pt[17:9];
        w[3] = pt[8:0];
        for (int r = 0; r < rounds; r++) begin
            a  = m_sb1(w[0] ^ k[(3 * r) % 16]);
            b  = m_sb2(w[1] ^ k[(3 * r + 1) % 16]);
            c  = m_sb1(w[2] ^ k[(3 * r + 2) % 16] ^ 9'(r % 128));
            t0 = w[0];
            w[0] = w[1] ^ a;
            w[1] = w[2] ^ b;
            w[2] = w[3] ^ c;
            w[3] = t0;
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    function automatic logic [143:0] rnd144();
        return 144'({$urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom()});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called right after the start edge; counts edges until done.
    task automatic wait_done(input logic [35:0] exp,
                             input bit hold,
                             input bit perturb,
                             input logic [35:0] prev,
                             input string tag);
        int n;
        n = 0;
        if (!hold) en24 = 1'b0;
        while (done24 !== 1'b1 && n < 40) begin
            if (perturb) begin
                si24 = rnd36();
                k24  = rnd144();
            end
            step();
            n++;
            if (n == 12) chk({tag, "_mid_sj"}, 64'(sj24), 64'(prev));
        end
        chk({tag, "_lat"}, 64'(n), 64'd24);
        chk({tag, "_sj"}, 64'(sj24), 64'(exp));
        chk({tag, "_rn"}, 64'(rn24), 64'd24);
    endtask

    initial begin
        logic [35:0]  pt, pt2, exp, exp2, prev;
        logic [143:0] key, key2;
        logic [8:0]   x, g1, g2;
        bit           seen [512];
        int           uniq;

        rst  = 1'b1;
        en1  = 1'b0;
        en24 = 1'b0;
        si1  = '0;
        si24 = '0;
        k1   = '0;
        k24  = '0;
        step();
        step();
        chk("rst_sj24", 64'(sj24), 64'd0);
        chk("rst_done24", 64'(done24), 64'd0);
        chk("rst_rn24", 64'(rn24), 64'd0);
        chk("rst_sj1", 64'(sj1), 64'd0);
        rst = 1'b0;
        step();

        // One-round directed vectors
        en1 = 1'b1;
        step();
        en1 = 1'b0;
        chk("r1_busy_done", 64'(done1), 64'd0);
        step();
        chk("r1_zero_done", 64'(done1), 64'd1);
        chk("r1_zero_sj", 64'(sj1), 64'h002940000);
        chk("r1_zero_rn", 64'(rn1), 64'd1);

        si1 = 36'h008000000;
        en1 = 1'b1;
        step();
        en1 = 1'b0;
        step();
        chk("r1_w0_done", 64'(done1), 64'd1);
        chk("r1_w0_sj", 64'(sj1), 64'h40A940001);

        // Random 24-round runs: plain, enable held, inputs perturbed, both
        for (int t = 0; t < 4; t++) begin
            pt   = rnd36();
            key  = rnd144();
            exp  = model(pt, key, 24);
            prev = sj24;
            si24 = pt;
            k24  = key;
            en24 = 1'b1;
            step();
            chk("rand_start_rn", 64'(rn24), 64'd0);
            chk("rand_start_done", 64'(done24), 64'd0);
            wait_done(exp, t[0], t[1], prev, "rand");
            en24 = 1'b0;
            step();
            chk("rand_hold_sj", 64'(sj24), 64'(exp));
            chk("rand_hold_done", 64'(done24), 64'd1);
        end

        // Back-to-back with enable held through DONE
        pt   = rnd36();
        key  = rnd144();
        exp  = model(pt, key, 24);
        pt2  = rnd36();
        key2 = rnd144();
        exp2 = model(pt2, key2, 24);
        prev = sj24;
        si24 = pt;
        k24  = key;
        en24 = 1'b1;
        step();
        wait_done(exp, 1'b1, 1'b0, prev, "b2b_first");
        si24 = pt2;
        k24  = key2;
        step();
        chk("b2b_restart_done", 64'(done24), 64'd0);
        chk("b2b_restart_rn", 64'(rn24), 64'd0);
        chk("b2b_restart_sj", 64'(sj24), 64'(exp));
        wait_done(exp2, 1'b0, 1'b1, exp, "b2b_second");
        en24 = 1'b0;
        step();

        // Asynchronous reset in the middle of an encryption
        si24 = rnd36();
        k24  = rnd144();
        en24 = 1'b1;
        step();
        en24 = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("mid_rn", 64'(rn24), 64'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sj", 64'(sj24), 64'd0);
        chk("arst_done", 64'(done24), 64'd0);
        chk("arst_rn", 64'(rn24), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_done", 64'(done24), 64'd0);
        pt   = rnd36();
        key  = rnd144();
        exp  = model(pt, key, 24);
        si24 = pt;
        k24  = key;
        en24 = 1'b1;
        step();
        wait_done(exp, 1'b0, 1'b0, 36'd0, "post_rst");

        // Exhaustive S-box recovery: w0=w1=x, w2=w3=0, zero key, one round
        for (int i = 0; i < 512; i++) seen[i] = 1'b0;
        k1 = '0;
        for (int i = 0; i < 512; i++) begin
            x   = 9'(i);
            si1 = {x, x, 9'd0, 9'd0};
            en1 = 1'b1;
            step();
            en1 = 1'b0;
            step();
            g1 = sj1[35:27] ^ x;
            g2 = sj1[26:18];
            chk("sb1", 64'(g1), 64'(m_sb1(x)));
            chk("sb2", 64'(g2), 64'(m_sb2(x)));
            seen[g1] = 1'b1;
        end
        uniq = 0;
        for (int i = 0; i < 512; i++) if (seen[i]) uniq++;
        chk("sb1_bijective", 64'(uniq), 64'd512);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
